// File: rtl/seq_pkg.sv
// Shared opcode definitions for the microprogram sequencer.
package seq_pkg;

    localparam int SEQ_OP_W = 4;

    localparam logic [SEQ_OP_W-1:0] SEQ_CONT = 4'd0;
    localparam logic [SEQ_OP_W-1:0] SEQ_JMP  = 4'd1;
    localparam logic [SEQ_OP_W-1:0] SEQ_JSR  = 4'd2;
    localparam logic [SEQ_OP_W-1:0] SEQ_RTS  = 4'd3;
    localparam logic [SEQ_OP_W-1:0] SEQ_CASE = 4'd4;
    localparam logic [SEQ_OP_W-1:0] SEQ_LDCT = 4'd5;
    localparam logic [SEQ_OP_W-1:0] SEQ_RPCT = 4'd6;
    localparam logic [SEQ_OP_W-1:0] SEQ_PUSH = 4'd7;
    localparam logic [SEQ_OP_W-1:0] SEQ_RFCT = 4'd8;
    localparam logic [SEQ_OP_W-1:0] SEQ_JMAP = 4'd9;

endpackage

// File: rtl/micro_sequencer_if.sv
// Pipeline-register / code-ROM side bundle of the microprogram sequencer.
interface micro_sequencer_if
    import seq_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int COND_W = 8,
    parameter int CASE_W = 4
);
    localparam int SEL_W = (COND_W > 1) ? $clog2(COND_W) : 1;

    logic [SEQ_OP_W-1:0] op;
    logic [ADDR_W-1:0]   d_in;
    logic [ADDR_W-1:0]   map_in;
    logic [CASE_W-1:0]   case_in;
    logic [COND_W-1:0]   cond_in;
    logic [SEL_W-1:0]    cond_sel;
    logic                cond_pol;
    logic                stall;
    logic [ADDR_W-1:0]   uaddr;
    logic                cnt_zero;
    logic                stack_full;
    logic                stack_empty;
    logic                stack_err;

    // Pipeline side: drives the microinstruction fields, observes the address.
    modport master (
        output op, d_in, map_in, case_in, cond_in, cond_sel, cond_pol, stall,
        input  uaddr, cnt_zero, stack_full, stack_empty, stack_err
    );

    // Sequencer side.
    modport slave (
        input  op, d_in, map_in, case_in, cond_in, cond_sel, cond_pol, stall,
        output uaddr, cnt_zero, stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/seq_stack.sv
// Return-address LIFO. Entry 0 is top of stack; a push when full shifts the
// oldest entry out so the newest STACK_DEPTH return addresses survive.
module seq_stack #(
    parameter int ADDR_W     = 11,
    parameter int DEPTH      = 4,
    parameter int RESET_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              peek,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] tos,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);
    localparam int SP_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] mem_reg  [DEPTH];
    logic [ADDR_W-1:0] mem_next [DEPTH];
    logic [SP_W-1:0]   sp_reg;
    logic [SP_W-1:0]   sp_next;

    assign full      = (sp_reg == SP_W'(DEPTH));
    assign empty     = (sp_reg == '0);
    assign overflow  = push & full;
    assign underflow = (pop | peek) & empty;
    // Reading an empty stack yields the reset address so a stray return restarts.
    assign tos       = empty ? ADDR_W'(RESET_ADDR) : mem_reg[0];

    // Per-entry shift: push moves everything one deeper, pop moves one shallower.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (gi == 0) begin : g_top
                if (DEPTH > 1) begin : g_deep
                    assign mem_next[gi] = push ? push_data : mem_reg[gi + 1];
                end else begin : g_single
                    assign mem_next[gi] = push_data;
                end
            end else if (gi == DEPTH - 1) begin : g_bottom
                assign mem_next[gi] = push ? mem_reg[gi - 1] : mem_reg[gi];
            end else begin : g_mid
                assign mem_next[gi] = push ? mem_reg[gi - 1] : mem_reg[gi + 1];
            end
        end
    endgenerate

    // Saturating stack pointer: stays at DEPTH on overflow and at 0 on underflow.
    always_comb begin
        sp_next = sp_reg;
        if (push && !full)
            sp_next = sp_reg + SP_W'(1);
        else if (pop && !empty)
            sp_next = sp_reg - SP_W'(1);
    end

    // Contents are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge clock) begin
        if (push || pop)
            mem_reg <= mem_next;
    end

    // Stack pointer register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            sp_reg <= '0;
        else
            sp_reg <= sp_next;
    end
endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: next-address mux, condition select, loop counter,
// and the sticky stack error flag around the return-stack sub-block.
module micro_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = 8,
    parameter int COND_W      = 8,
    parameter int CASE_W      = 4,
    parameter int RESET_ADDR  = 0
) (
    input  logic              clock,
    input  logic              reset,
    micro_sequencer_if.slave  bus
);
    logic [ADDR_W-1:0] uaddr_reg, uaddr_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              err_reg;
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] tos;
    logic              pass;
    logic              cnt_zero;
    logic              push_req, pop_req, peek_req;
    logic              full, empty, overflow, underflow;

    assign pass     = bus.cond_in[bus.cond_sel] ^ bus.cond_pol;
    assign inc      = uaddr_reg + ADDR_W'(1);
    assign cnt_zero = (cnt_reg == '0);

    // Opcode decode into next address, counter update and stack requests.
    always_comb begin
        uaddr_next = inc;
        cnt_next   = cnt_reg;
        push_req   = 1'b0;
        pop_req    = 1'b0;
        peek_req   = 1'b0;
        case (bus.op)
            SEQ_JMP:  if (pass) uaddr_next = bus.d_in;
            SEQ_JSR:  if (pass) begin
                          push_req   = 1'b1;
                          uaddr_next = bus.d_in;
                      end
            SEQ_RTS:  if (pass) begin
                          pop_req    = 1'b1;
                          uaddr_next = tos;
                      end
            SEQ_CASE: uaddr_next = bus.d_in | ADDR_W'(bus.case_in);
            SEQ_LDCT: cnt_next = bus.d_in[CNT_W-1:0];
            SEQ_RPCT: if (!cnt_zero) begin
                          cnt_next   = cnt_reg - CNT_W'(1);
                          uaddr_next = bus.d_in;
                      end
            SEQ_PUSH: push_req = 1'b1;
            SEQ_RFCT: if (!cnt_zero) begin
                          cnt_next   = cnt_reg - CNT_W'(1);
                          peek_req   = 1'b1;
                          uaddr_next = tos;
                      end else begin
                          pop_req    = 1'b1;
                      end
            SEQ_JMAP: uaddr_next = bus.map_in;
            default:  ;
        endcase
    end

    seq_stack #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (STACK_DEPTH),
        .RESET_ADDR (RESET_ADDR)
    ) u_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (push_req & ~bus.stall),
        .pop       (pop_req & ~bus.stall),
        .peek      (peek_req & ~bus.stall),
        .push_data (inc),
        .tos       (tos),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Address, counter and sticky error advance only when not stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            uaddr_reg <= ADDR_W'(RESET_ADDR);
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else if (!bus.stall) begin
            uaddr_reg <= uaddr_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_reg | overflow | underflow;
        end
    end

    assign bus.uaddr       = uaddr_reg;
    assign bus.cnt_zero    = cnt_zero;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.stack_err   = err_reg;
endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed table, hand sequences for
// reset and stack overflow/underflow, then randomized ops against a queue model.
module tb_micro_sequencer;
    import seq_pkg::*;

    localparam int ADDR_W = 11;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;
    localparam int COND_W = 8;
    localparam int CASE_W = 4;

    logic clock;
    logic reset;

    micro_sequencer_if #(.ADDR_W(ADDR_W), .COND_W(COND_W), .CASE_W(CASE_W)) bus ();

    micro_sequencer #(
        .ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .CNT_W(CNT_W),
        .COND_W(COND_W), .CASE_W(CASE_W), .RESET_ADDR(0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state: address, counter, return stack as a queue (front = newest).
    int m_ua;
    int m_cnt;
    int m_err;
    int m_stk[$];

    typedef struct {
        logic [3:0]  op;
        logic [10:0] d;
        logic [3:0]  cs;
        logic        pol;
        logic        st;
        logic [10:0] ua;
        logic        cz;
        logic        emp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ua = 0; m_cnt = 0; m_err = 0;
        m_stk.delete();
    endtask

    task automatic m_push(input int v);
        if (m_stk.size() == DEPTH) begin
            void'(m_stk.pop_back());
            m_err = 1;
        end
        m_stk.push_front(v);
    endtask

    task automatic m_pop(output int v);
        if (m_stk.size() == 0) begin
            m_err = 1;
            v = 0;
        end else begin
            v = m_stk.pop_front();
        end
    endtask

    task automatic m_peek(output int v);
        if (m_stk.size() == 0) begin
            m_err = 1;
            v = 0;
        end else begin
            v = m_stk[0];
        end
    endtask

    task automatic model_step(input int op, input int d, input int mp, input int cs,
                              input int cond, input int sel, input int pol, input int st);
        int pass, inc, nx, t;
        if (st != 0) return;
        pass = ((cond >> sel) & 1) ^ pol;
        inc  = (m_ua + 1) % (1 << ADDR_W);
        nx   = inc;
        case (op)
            1: if (pass != 0) nx = d;
            2: if (pass != 0) begin m_push(inc); nx = d; end
            3: if (pass != 0) begin m_pop(t); nx = t; end
            4: nx = d | cs;
            5: m_cnt = d % (1 << CNT_W);
            6: if (m_cnt > 0) begin m_cnt--; nx = d; end
            7: m_push(inc);
            8: if (m_cnt > 0) begin m_cnt--; m_peek(t); nx = t; end
               else m_pop(t);
            9: nx = mp;
            default: nx = inc;
        endcase
        m_ua = nx;
    endtask

    task automatic drive(input int op, input int d, input int mp, input int cs,
                         input int cond, input int sel, input int pol, input int st);
        bus.op       = 4'(op);
        bus.d_in     = 11'(d);
        bus.map_in   = 11'(mp);
        bus.case_in  = 4'(cs);
        bus.cond_in  = 8'(cond);
        bus.cond_sel = 3'(sel);
        bus.cond_pol = 1'(pol);
        bus.stall    = 1'(st);
    endtask

    // Apply one microinstruction across one clock edge; outputs sampled 1 time unit after.
    task automatic step(input int op, input int d, input int mp, input int cs,
                        input int cond, input int sel, input int pol, input int st);
        drive(op, d, mp, cs, cond, sel, pol, st);
        model_step(op, d, mp, cs, cond, sel, pol, st);
        @(posedge clock);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".uaddr"},       int'(bus.uaddr),       m_ua);
        chk({tag, ".cnt_zero"},    int'(bus.cnt_zero),    (m_cnt == 0) ? 1 : 0);
        chk({tag, ".stack_full"},  int'(bus.stack_full),  (m_stk.size() == DEPTH) ? 1 : 0);
        chk({tag, ".stack_empty"}, int'(bus.stack_empty), (m_stk.size() == 0) ? 1 : 0);
        chk({tag, ".stack_err"},   int'(bus.stack_err),   m_err);
    endtask

    task automatic add(input int op, input int d, input int cs, input int pol, input int st,
                       input int ua, input int cz, input int emp);
        vec_t v;
        v.op = 4'(op); v.d = 11'(d); v.cs = 4'(cs); v.pol = 1'(pol); v.st = 1'(st);
        v.ua = 11'(ua); v.cz = 1'(cz); v.emp = 1'(emp);
        vecs.push_back(v);
    endtask

    initial begin
        int rts_exp[5];
        rts_exp[0] = 'h401; rts_exp[1] = 'h301; rts_exp[2] = 'h201;
        rts_exp[3] = 'h101; rts_exp[4] = 'h000;

        // Directed table: starts right after reset, cond_in bit0=1, cond_sel=0.
        add(0, 0, 0, 0, 0, 'h001, 1, 1);
        add(0, 0, 0, 0, 0, 'h002, 1, 1);
        add(0, 0, 0, 0, 0, 'h003, 1, 1);
        add(1, 'h010, 0, 0, 0, 'h010, 1, 1);
        add(2, 'h100, 0, 0, 0, 'h100, 1, 0);
        add(3, 0, 0, 0, 0, 'h011, 1, 1);
        add(2, 'h100, 0, 1, 0, 'h012, 1, 1);
        add(3, 0, 0, 1, 0, 'h013, 1, 1);
        add(5, 3, 0, 0, 0, 'h014, 0, 1);
        add(6, 'h040, 0, 0, 0, 'h040, 0, 1);
        add(6, 'h040, 0, 0, 0, 'h040, 0, 1);
        add(6, 'h040, 0, 0, 0, 'h040, 1, 1);
        add(6, 'h040, 0, 0, 0, 'h041, 1, 1);
        add(4, 'h200, 5, 0, 0, 'h205, 1, 1);
        add(9, 'h3C7, 0, 0, 0, 'h3C7, 1, 1);
        add(1, 'h7FF, 0, 0, 0, 'h7FF, 1, 1);
        add(0, 0, 0, 0, 0, 'h000, 1, 1);
        add(5, 3, 0, 0, 0, 'h001, 0, 1);
        add(7, 0, 0, 0, 0, 'h002, 0, 0);
        add(0, 0, 0, 0, 0, 'h003, 0, 0);
        add(8, 0, 0, 0, 0, 'h002, 0, 0);
        add(0, 0, 0, 0, 0, 'h003, 0, 0);
        add(8, 0, 0, 0, 0, 'h002, 0, 0);
        add(0, 0, 0, 0, 0, 'h003, 0, 0);
        add(8, 0, 0, 0, 0, 'h002, 1, 0);
        add(0, 0, 0, 0, 0, 'h003, 1, 0);
        add(8, 0, 0, 0, 0, 'h004, 1, 1);
        add(5, 2, 0, 0, 0, 'h005, 0, 1);
        add(6, 'h040, 0, 0, 1, 'h005, 0, 1);
        add(6, 'h040, 0, 0, 1, 'h005, 0, 1);
        add(6, 'h040, 0, 0, 1, 'h005, 0, 1);
        add(6, 'h040, 0, 0, 0, 'h040, 0, 1);
        add(2, 'h123, 0, 0, 1, 'h040, 0, 1);
        add(2, 'h123, 0, 0, 1, 'h040, 0, 1);
        add(2, 'h123, 0, 0, 1, 'h040, 0, 1);
        add(2, 'h123, 0, 0, 0, 'h123, 0, 0);
        add(3, 0, 0, 0, 0, 'h041, 0, 1);
        add(6, 'h060, 0, 0, 0, 'h060, 1, 1);
        add(6, 'h060, 0, 0, 0, 'h061, 1, 1);

        // Power-on reset.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_model("por");
        reset = 1'b0;

        // Reset asserted mid-run takes effect without waiting for a clock edge.
        step(1, 'h02A, 0, 0, 1, 0, 0, 0);
        chk("pre_reset.uaddr", int'(bus.uaddr), 'h02A);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_reset.uaddr", int'(bus.uaddr), 0);
        chk("async_reset.err", int'(bus.stack_err), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Directed table.
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].op, vecs[i].d, vecs[i].d, vecs[i].cs, 1, 0, vecs[i].pol, vecs[i].st);
            chk($sformatf("vec%0d.uaddr", i), int'(bus.uaddr), int'(vecs[i].ua));
            chk($sformatf("vec%0d.cnt_zero", i), int'(bus.cnt_zero), int'(vecs[i].cz));
            chk($sformatf("vec%0d.stack_empty", i), int'(bus.stack_empty), int'(vecs[i].emp));
            chk($sformatf("vec%0d.stack_err", i), int'(bus.stack_err), 0);
            $display("vec %0d op=%0d d=0x%0h stall=%0d -> uaddr=0x%0h", i, vecs[i].op,
                     vecs[i].d, vecs[i].st, bus.uaddr);
        end

        // Overflow: five nested calls into a four-deep stack.
        for (int k = 1; k <= 5; k++) begin
            step(2, k * 'h100, 0, 0, 1, 0, 0, 0);
            check_model($sformatf("jsr%0d", k));
        end
        chk("ovf.stack_full", int'(bus.stack_full), 1);
        chk("ovf.stack_err", int'(bus.stack_err), 1);
        // Returns come back newest first; the fifth finds the stack empty.
        for (int k = 0; k < 5; k++) begin
            step(3, 0, 0, 0, 1, 0, 0, 0);
            chk($sformatf("rts%0d.uaddr", k), int'(bus.uaddr), rts_exp[k]);
            check_model($sformatf("rts%0d", k));
        end
        chk("unf.stack_empty", int'(bus.stack_empty), 1);

        // Sticky error clears only through reset.
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_model("rst2");

        // Randomized microinstruction stream against the model.
        for (int i = 0; i < 600; i++) begin
            int op, d, mp, cs, cond, sel, pol, st;
            op   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                               : int'($urandom_range(0, 9));
            d    = int'($urandom_range(0, 2047));
            if (op == 5) d = int'($urandom_range(0, 6));
            mp   = int'($urandom_range(0, 2047));
            cs   = int'($urandom_range(0, 15));
            cond = int'($urandom_range(0, 255));
            sel  = int'($urandom_range(0, 7));
            pol  = int'($urandom_range(0, 1));
            st   = ($urandom_range(0, 9) == 0) ? 1 : 0;
            step(op, d, mp, cs, cond, sel, pol, st);
            check_model($sformatf("rand%0d", i));
            $display("rand %0d op=%0d d=0x%0h stall=%0d -> uaddr=0x%0h sp_model=%0d", i, op,
                     d, st, bus.uaddr, m_stk.size());
            if (i == 300) begin
                reset = 1'b1;
                model_reset();
                #1;
                check_model("rand_reset");
                @(posedge clock);
                #1;
                reset = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
